// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU with a HI/LO register pair.
//   Single-cycle ops (add/sub/logic/slt/mfhi/mflo) finish the cycle after acceptance;
//   mult/multu/div/divu iterate one bit per cycle and finish WIDTH+1 cycles after acceptance.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i                request, accepted only while idle
//   aluop_i, funct_i       operation class and R-type function code
//   a_i, b_i               operands, captured at acceptance
//   busy_o, done_o         busy through the done cycle; done is a one-cycle pulse
//   result_o, zero_o, err_o result (held until next done), zero flag, unsupported-op flag
//   hi_o, lo_o             HI/LO registers
module alu_seq_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       aluop_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;        // original dividend, needed for divide by zero
  logic [WIDTH-1:0]  mcand_q, mcand_d; // |multiplicand| or |divisor|
  logic [WIDTH-1:0]  p_hi_q, p_hi_d;   // partial product high / running remainder
  logic [WIDTH-1:0]  p_lo_q, p_lo_d;   // multiplier bits / dividend-quotient shift register
  logic              neg_q, neg_d;     // negate product or quotient at the end
  logic              rneg_q, rneg_d;   // negate remainder at the end
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Decode of the incoming request
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;
  logic             is_mul;
  logic             is_div;

  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
    unique case (aluop_i)
      2'b00: sc_res = a_i + b_i;
      2'b01: sc_res = a_i - b_i;
      2'b11: sc_res = WIDTH'($signed(a_i) < $signed(b_i));
      default: begin
        case (funct_i)
          FnAdd:            sc_res = a_i + b_i;
          FnSub:            sc_res = a_i - b_i;
          FnAnd:            sc_res = a_i & b_i;
          FnOr:             sc_res = a_i | b_i;
          FnXor:            sc_res = a_i ^ b_i;
          FnNor:            sc_res = ~(a_i | b_i);
          FnSlt:            sc_res = WIDTH'($signed(a_i) < $signed(b_i));
          FnSltu:           sc_res = WIDTH'(a_i < b_i);
          FnMfhi:           sc_res = hi_q;
          FnMflo:           sc_res = lo_q;
          FnMult, FnMultu:  is_mul = 1'b1;
          FnDiv, FnDivu: begin
            if (DIV_EN) is_div = 1'b1;
            else        sc_err = 1'b1;
          end
          default:          sc_err = 1'b1;
        endcase
      end
    endcase
  end

  // Signed variants have funct[0] clear; iterate on magnitudes and fix signs at the end
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    op_signed = ~funct_i[0];
    a_neg     = op_signed & a_i[WIDTH-1];
    b_neg     = op_signed & b_i[WIDTH-1];
    a_abs     = a_neg ? -a_i : a_i;
    b_abs     = b_neg ? -b_i : b_i;
  end

  // One shift-add multiply step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], p_lo_q[WIDTH-1:1]};
    prod_fix = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
  end

  // One restoring divide step
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    rem_sh  = {p_hi_q, p_lo_q[WIDTH-1]};
    fits    = rem_sh >= {1'b0, mcand_q};
    // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice
    div_hi  = fits ? (rem_sh[WIDTH-1:0] - mcand_q) : rem_sh[WIDTH-1:0];
    div_lo  = {p_lo_q[WIDTH-2:0], fits};
    quo_fix = neg_q ? -div_lo : div_lo;
    rem_fix = rneg_q ? -div_hi : div_hi;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    mcand_d  = mcand_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          mcand_d = b_abs;
          p_hi_d  = '0;
          p_lo_d  = a_abs;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          div0_d  = (b_i == '0);
          if (is_mul) begin
            state_d = StMul;
          end else if (is_div) begin
            state_d = StDiv;
          end else begin
            result_d = sc_res;
            zero_d   = (sc_res == '0);
            err_d    = sc_err;
            state_d  = StFin;
          end
        end
      end
      StMul: begin
        p_hi_d = mul_hi;
        p_lo_d = mul_lo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          hi_d     = prod_fix[2*WIDTH-1:WIDTH];
          lo_d     = prod_fix[WIDTH-1:0];
          result_d = prod_fix[WIDTH-1:0];
          zero_d   = (prod_fix[WIDTH-1:0] == '0);
          state_d  = StFin;
        end
      end
      StDiv: begin
        p_hi_d = div_hi;
        p_lo_d = div_lo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          if (div0_q) begin
            hi_d     = a_q;
            lo_d     = '1;
            result_d = '1;
            zero_d   = 1'b0;
          end else begin
            hi_d     = rem_fix;
            lo_d     = quo_fix;
            result_d = quo_fix;
            zero_d   = (quo_fix == '0);
          end
          state_d = StFin;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      mcand_q  <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      mcand_q  <= mcand_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StFin);
  assign err_o    = done_o & err_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: 32-bit instance checked through a scoreboard,
// plus an 8-bit instance for the narrow signed-overflow divide case.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, done, zero, err;
  logic [31:0] result, hi, lo;

  logic        start8;
  logic [1:0]  aluop8;
  logic [5:0]  funct8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, err8;
  logic [7:0]  result8, hi8, lo8;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .DIV_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .aluop_i(aluop), .funct_i(funct),
    .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .result_o(result), .zero_o(zero),
    .err_o(err), .hi_o(hi), .lo_o(lo)
  );

  alu_seq_unit #(.WIDTH(8), .DIV_EN(1'b1)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .aluop_i(aluop8), .funct_i(funct8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .result_o(result8), .zero_o(zero8),
    .err_o(err8), .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model built on the language's own arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, q, r;
    e.res = '0; e.hi = hi_in; e.lo = lo_in; e.err = 1'b0; e.lat = 1; e.acc = 0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (op)
      2'b00: e.res = av + bv;
      2'b01: e.res = av - bv;
      2'b11: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        case (fn)
          6'h20: e.res = av + bv;
          6'h22: e.res = av - bv;
          6'h24: e.res = av & bv;
          6'h25: e.res = av | bv;
          6'h26: e.res = av ^ bv;
          6'h27: e.res = ~(av | bv);
          6'h2a: e.res = (sa < sb) ? 32'd1 : 32'd0;
          6'h2b: e.res = (av < bv) ? 32'd1 : 32'd0;
          6'h10: e.res = hi_in;
          6'h12: e.res = lo_in;
          6'h18, 6'h19: begin
            if (fn == 6'h18) p = sa * sb;
            else             p = {32'b0, av} * {32'b0, bv};
            e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = 33;
          end
          6'h1a, 6'h1b: begin
            e.lat = 33;
            if (bv == '0) begin
              e.lo = '1; e.hi = av;
            end else if (fn == 6'h1a) begin
              q = sa / sb; r = sa % sb;
              e.lo = q[31:0]; e.hi = r[31:0];
            end else begin
              e.lo = av / bv; e.hi = av % bv;
            end
            e.res = e.lo;
          end
          default: begin e.err = 1'b1; e.res = '0; end
        endcase
      end
    endcase
    return e;
  endfunction

  // Scoreboard consumer: compares on every done pulse, sampled mid-cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", result, e.res);
        check_eq("zero", zero, e.res == '0);
        check_eq("err", err, e.err);
        check_eq("hi", hi, e.hi);
        check_eq("lo", lo, e.lo);
        check_eq("latency", cyc - e.acc, e.lat);
        check_eq("busy_in_done", busy, 1'b1);
      end
    end
  end

  // Issue one op; inputs are scrambled afterwards, and when noisy start is held high
  // with junk through the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv, input bit noisy);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) check_eq("idle_wait_timeout", busy, 1'b0);
    aluop = op; funct = fn; a = av; b = bv; start = 1'b1;
    e = model(op, fn, av, bv, m_hi, m_lo);
    e.acc = cyc;
    m_hi = e.hi; m_lo = e.lo;
    sb_q.push_back(e);
    @(negedge clk);
    if (!noisy) begin
      start = 1'b0;
      a = $urandom; b = $urandom; funct = 6'($urandom); aluop = 2'($urandom);
    end else begin
      n = 0;
      while (!done && n < 100) begin
        a = $urandom; b = $urandom; funct = 6'($urandom); aluop = 2'($urandom);
        start = 1'b1;
        @(negedge clk);
        n++;
      end
      if (!done) check_eq("done_timeout", done, 1'b1);
      start = 1'b1;  // still high across the edge that ends the done cycle
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  logic [5:0] fl[16];
  int         k8;

  initial begin
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
           6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f, 6'h00};
    rst_n = 1'b0; start = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
    start8 = 1'b0; aluop8 = '0; funct8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_zero", zero, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit signed overflow divide with start pulsed while busy
    aluop8 = 2'b10; funct8 = 6'h1a; a8 = 8'h80; b8 = 8'hff; start8 = 1'b1;
    k8 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start8 = (k >= 2 && k <= 8);
      a8 = 8'h03; b8 = 8'h01; funct8 = 6'h19;
      if (done8) begin k8 = k; break; end
    end
    start8 = 1'b0;
    check_eq("w8_latency", k8, 9);
    check_eq("w8_lo", lo8, 8'h80);
    check_eq("w8_hi", hi8, 8'h00);
    check_eq("w8_err", err8, 1'b0);
    @(negedge clk);
    check_eq("w8_busy_after", busy8, 1'b0);

    // Directed 32-bit cases
    run_op(2'b10, 6'h22, 32'd5, 32'd7, 1'b0);
    run_op(2'b00, 6'h00, 32'h7fffffff, 32'd1, 1'b0);
    run_op(2'b01, 6'h3f, 32'd3, 32'd3, 1'b0);
    run_op(2'b11, 6'h00, 32'hfffffff0, 32'd2, 1'b0);
    run_op(2'b10, 6'h24, 32'hf0f0a5a5, 32'hff00ff00, 1'b0);
    run_op(2'b10, 6'h25, 32'hf0f0a5a5, 32'h0f0f0000, 1'b0);
    run_op(2'b10, 6'h26, 32'hf0f0a5a5, 32'hf0f0a5a5, 1'b0);
    run_op(2'b10, 6'h27, 32'h00000000, 32'h0000ffff, 1'b0);
    run_op(2'b10, 6'h2a, 32'hffffffff, 32'd1, 1'b0);
    run_op(2'b10, 6'h2b, 32'hffffffff, 32'd1, 1'b0);
    run_op(2'b10, 6'h18, 32'hffffffff, 32'd3, 1'b1);
    run_op(2'b10, 6'h19, 32'hffffffff, 32'd3, 1'b0);
    run_op(2'b10, 6'h10, 32'd0, 32'd0, 1'b0);
    run_op(2'b10, 6'h12, 32'd0, 32'd0, 1'b0);
    run_op(2'b10, 6'h1a, -32'sd7, 32'd2, 1'b0);
    run_op(2'b10, 6'h1b, 32'd9, 32'd0, 1'b1);
    run_op(2'b10, 6'h1a, -32'sd9, 32'd0, 1'b0);
    run_op(2'b10, 6'h1a, 32'h80000000, 32'hffffffff, 1'b0);
    run_op(2'b10, 6'h1a, 32'd7, -32'sd2, 1'b0);
    run_op(2'b10, 6'h3f, 32'd1, 32'd2, 1'b0);
    run_op(2'b10, 6'h10, 32'd0, 32'd0, 1'b0);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), fl[$urandom_range(0, 15)], $urandom,
             ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset during a multiply, then an add right after reset releases
    run_op(2'b10, 6'h18, 32'h12345678, 32'h9abcdef0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);
    rst_n = 1'b1;
    run_op(2'b00, 6'h00, 32'd40, 32'd2, 1'b0);

    repeat (40) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 Parameter DIV_EN, default 1; when 0, divide funct codes are treated as unsupported.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 start  in  1  operation request; accepted only when busy=0.
REQ-006 aluop  in  2  operation class: 00 add, 01 sub, 10 decode funct, 11 slt.
REQ-007 funct  in  6  R-type function code; used only when aluop=10.
REQ-008 a  in  WIDTH  operand A; captured at acceptance.
REQ-009 b  in  WIDTH  operand B; captured at acceptance.
REQ-010 busy  out  1  high from the cycle after acceptance until the cycle done is asserted, inclusive.
REQ-011 done  out  1  one-cycle pulse; result, zero and err are valid in the same cycle.
REQ-012 result  out  WIDTH  registered result; holds its value until the next done.
REQ-013 zero  out  1  high when result is all zeros; updated with done.
REQ-014 err  out  1  high with done when the funct code is unsupported.
REQ-015 hi  out  WIDTH  HI register (product upper half, or remainder).
REQ-016 lo  out  WIDTH  LO register (product lower half, or quotient).

Function
REQ-017 Single-cycle ops: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010 (signed), sltu 101011, mfhi 010000, mflo 010010.
REQ-018 Single-cycle ops: done is asserted the cycle after acceptance, with busy high for that cycle only.
REQ-019 Multi-cycle ops: mult 011000, multu 011001, div 011010, divu 011011.
REQ-020 Multi-cycle ops: done is asserted exactly WIDTH+1 cycles after acceptance.
REQ-021 Multi-cycle ops: hi and lo update in the done cycle only.
REQ-022 Multi-cycle ops: result equals the new lo value.
REQ-023 State machine has states IDLE, MUL, DIV and FIN.
REQ-024 IDLE goes to MUL or DIV on acceptance of a multi-cycle op, otherwise goes to FIN.
REQ-025 MUL and DIV run WIDTH iterations (one bit per cycle), then go to FIN.
REQ-026 FIN asserts done and returns to IDLE.
REQ-027 add, sub and slt wrap modulo 2^WIDTH; no overflow trap.
REQ-028 slt and sltu return 1 zero-extended to WIDTH when true, else 0.
REQ-029 mult/multu: {hi,lo} is the full 2*WIDTH product, signed or unsigned respectively.
REQ-030 div/divu: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-031 Divide by zero: lo is all ones, hi equals a, err=0, and latency is unchanged.
REQ-032 Signed overflow (a = most negative, b = -1): lo = a, hi = 0.
REQ-033 Unsupported funct, or a divide with DIV_EN=0: result = 0, err = 1, hi and lo unchanged, single-cycle latency.
REQ-034 mfhi and mflo return the hi and lo values as they stood at acceptance.
REQ-035 start while busy=1 is ignored; it has no effect on state, operands or outputs.
REQ-036 start in the same cycle as done is ignored.
REQ-037 Operands and funct are registered at acceptance; later changes to the inputs do not affect the operation in progress.

Reset
REQ-038 reset=0 at a rising edge forces state IDLE.
REQ-039 reset=0 at a rising edge clears busy, done, err, zero, result, hi and lo to 0.
REQ-040 Reset asserted mid-operation aborts the operation with no done pulse, and a start in the first cycle after reset deasserts is accepted.

Verification
REQ-041 WIDTH=32, aluop=10, funct=100010, a=5, b=7 -> done at cycle+1, result=0xFFFFFFFE, zero=0.
REQ-042 WIDTH=32, mult, a=0xFFFFFFFF (-1), b=3 -> done at cycle+33, hi=0xFFFFFFFF, lo=0xFFFFFFFD; the same operands with multu -> hi=0x00000002, lo=0xFFFFFFFD.
REQ-043 WIDTH=32, div, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu, a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
REQ-044 WIDTH=8, div, a=0x80, b=0xFF -> done at cycle+9, lo=0x80, hi=0x00; start pulsed at cycles +2..+8 is ignored.
REQ-045 funct=111111 -> done at cycle+1, err=1, result=0, hi and lo unchanged; then mfhi -> result equals the prior hi.
REQ-046 reset=0 at iteration 10 of mult -> busy=0, no done pulse, hi=lo=0; a new add started the following cycle completes normally.
